ocm_arbiter: RTL and testbench

Sequencer and arbiter for the single-port 32-bit on-chip terrain/sprite table. It shares the RAM between the NIOS Avalon-MM slave port and two burst-read clients: client 0 is the renderer and client 1 is the collision engine. It serialises every access, generates burst addresses, bounds-checks each request and streams read beats back with a one-cycle RAM latency. It sits between the Avalon interconnect, the draw/collision engines and the RAM macro.

---
 rtl/ocm_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_ocm_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocm_arbiter.sv
// Sequencer/arbiter sharing the single-port terrain/sprite RAM between Avalon-MM and two burst readers.
// Latency: Avalon write 2 cycles, Avalon read 3 cycles, burst beats start 2 cycles after grant.
// Backpressure: Avalon stalls via waitrequest; burst clients hold req until a one-cycle grant pulse.
//
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   avl_*                   : Avalon-MM slave (word addressed, 32-bit, byte enables)
//   b0_* / b1_*             : burst read clients (0 = renderer, 1 = collision engine)
//   ram_*                   : single-port RAM macro, read data one cycle after address
module ocm_arbiter #(
    parameter int DEPTH = 1500,
    parameter int AW    = 11,
    parameter int MAXB  = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,

    input  logic          avl_read_i,
    input  logic          avl_write_i,
    input  logic [AW-1:0] avl_address_i,
    input  logic [3:0]    avl_byteenable_i,
    input  logic [31:0]   avl_writedata_i,
    output logic [31:0]   avl_readdata_o,
    output logic          avl_waitrequest_o,

    input  logic          b0_req_i,
    input  logic [AW-1:0] b0_addr_i,
    input  logic [4:0]    b0_len_i,
    output logic          b0_grant_o,
    output logic          b0_valid_o,
    output logic [31:0]   b0_data_o,
    output logic          b0_done_o,
    output logic          b0_err_o,

    input  logic          b1_req_i,
    input  logic [AW-1:0] b1_addr_i,
    input  logic [4:0]    b1_len_i,
    output logic          b1_grant_o,
    output logic          b1_valid_o,
    output logic [31:0]   b1_data_o,
    output logic          b1_done_o,
    output logic          b1_err_o,

    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [3:0]    ram_be_o,
    output logic [31:0]   ram_wdata_o,
    input  logic [31:0]   ram_rdata_i
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [4:0]  MAXB_W  = 5'(MAXB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AVL_WR,
        S_AVL_RD,
        S_AVL_RDWAIT,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;        // 0: Avalon wins a tie with b1, 1: b1 wins
    logic          owner_q, owner_d;  // burst owner: 0 = b0, 1 = b1
    logic          rej_q, rej_d;      // current burst was rejected at accept time
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    len_q, len_d;
    logic [4:0]    cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Arbitration (only acted upon in IDLE)
    // ------------------------------------------------------------------
    logic          avl_req;
    logic          win_b0, win_b1, win_avl;
    logic [AW-1:0] req_addr;
    logic [4:0]    req_len;
    logic [AW:0]   req_end;
    logic          req_bad;
    logic          avl_in_range;

    assign avl_req = avl_read_i | avl_write_i;

    // b0 always wins; Avalon and b1 only compete when b0 is quiet.
    assign win_b0  = b0_req_i;
    assign win_avl = ~b0_req_i & avl_req  & (~b1_req_i | ~rr_q);
    assign win_b1  = ~b0_req_i & b1_req_i & (~avl_req  |  rr_q);

    assign req_addr = win_b1 ? b1_addr_i : b0_addr_i;
    assign req_len  = win_b1 ? b1_len_i  : b0_len_i;

    // End address is computed one bit wider so a burst near the top of the
    // address space cannot wrap around and pass the bounds check.
    assign req_end = {1'b0, req_addr} + {{(AW-4){1'b0}}, req_len};
    assign req_bad = (req_len == 5'd0) | (req_len > MAXB_W) | (req_end > DEPTH_W);

    // Avalon master holds the address for the whole access, so the range
    // check can be taken straight from the port in every Avalon state.
    assign avl_in_range = ({1'b0, avl_address_i} < DEPTH_W);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            rej_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            rej_q   <= rej_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        rej_d   = rej_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_b0 | win_b1) begin
                    owner_d = win_b1;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    cnt_d   = '0;
                    rej_d   = req_bad;
                    // A rejected burst skips straight to the done/err cycle.
                    state_d = req_bad ? S_DRAIN : S_BURST;
                end else if (win_avl) begin
                    // Write takes precedence if a master raises both strobes.
                    state_d = avl_write_i ? S_AVL_WR : S_AVL_RD;
                end
                if (win_avl | win_b1) begin
                    rr_d = ~rr_q;
                end
            end
            S_AVL_WR: begin
                state_d = S_IDLE;
            end
            S_AVL_RD: begin
                state_d = S_AVL_RDWAIT;
            end
            S_AVL_RDWAIT: begin
                state_d = S_IDLE;
            end
            S_BURST: begin
                if (cnt_q == len_q - 5'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                rej_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic beat_vld;
    logic drain;

    // Address issued in BURST cycle n returns from the RAM in cycle n+1, so
    // a beat is present on every BURST cycle after the first and in DRAIN
    // (the final beat), unless the burst was rejected.
    assign beat_vld = ((state_q == S_BURST) && (cnt_q != 5'd0)) ||
                      ((state_q == S_DRAIN) && !rej_q);
    assign drain    = (state_q == S_DRAIN);

    always_comb begin
        ram_addr_o        = '0;
        ram_we_o          = 1'b0;
        ram_be_o          = 4'h0;
        ram_wdata_o       = 32'h0;
        avl_readdata_o    = 32'h0;
        avl_waitrequest_o = 1'b1;

        b0_grant_o = 1'b0;
        b0_valid_o = 1'b0;
        b0_data_o  = 32'h0;
        b0_done_o  = 1'b0;
        b0_err_o   = 1'b0;
        b1_grant_o = 1'b0;
        b1_valid_o = 1'b0;
        b1_data_o  = 32'h0;
        b1_done_o  = 1'b0;
        b1_err_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                b0_grant_o = win_b0;
                b1_grant_o = win_b1;
            end
            S_AVL_WR: begin
                ram_addr_o        = avl_address_i;
                // Out-of-range writes are silently dropped.
                ram_we_o          = avl_in_range;
                ram_be_o          = avl_byteenable_i;
                ram_wdata_o       = avl_writedata_i;
                avl_waitrequest_o = 1'b0;
            end
            S_AVL_RD: begin
                ram_addr_o = avl_address_i;
            end
            S_AVL_RDWAIT: begin
                ram_addr_o        = avl_address_i;
                avl_readdata_o    = avl_in_range ? ram_rdata_i : 32'h0;
                avl_waitrequest_o = 1'b0;
            end
            S_BURST: begin
                ram_addr_o = addr_q + {{(AW-5){1'b0}}, cnt_q};
            end
            S_DRAIN: begin
                ram_addr_o = '0;
            end
            default: begin
                ram_addr_o = '0;
            end
        endcase

        // Beat data comes straight from the RAM output register; only the
        // owning client ever sees it.
        if (owner_q) begin
            b1_valid_o = beat_vld;
            b1_data_o  = beat_vld ? ram_rdata_i : 32'h0;
            b1_done_o  = drain;
            b1_err_o   = drain & rej_q;
        end else begin
            b0_valid_o = beat_vld;
            b0_data_o  = beat_vld ? ram_rdata_i : 32'h0;
            b0_done_o  = drain;
            b0_err_o   = drain & rej_q;
        end
    end

endmodule

// File: tb/tb_ocm_arbiter.sv
// Bench for ocm_arbiter: behavioural RAM, transaction-level reference model
// (priority/round-robin order plus a shadow memory), a table of directed
// vectors, hand-written reset/contention sequences and randomized rounds.
module tb_ocm_arbiter;
    localparam int DEPTH = 1500;
    localparam int AW    = 11;
    localparam int MAXB  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          avl_read, avl_write;
    logic [AW-1:0] avl_address;
    logic [3:0]    avl_be;
    logic [31:0]   avl_wdata, avl_rdata;
    logic          avl_wait;
    logic          b0_req, b1_req;
    logic [AW-1:0] b0_addr, b1_addr;
    logic [4:0]    b0_len, b1_len;
    logic          b0_grant, b0_valid, b0_done, b0_err;
    logic          b1_grant, b1_valid, b1_done, b1_err;
    logic [31:0]   b0_data, b1_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata, ram_rdata;

    ocm_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAXB(MAXB)) dut (
        .clk_i(clk), .reset_i(reset),
        .avl_read_i(avl_read), .avl_write_i(avl_write), .avl_address_i(avl_address),
        .avl_byteenable_i(avl_be), .avl_writedata_i(avl_wdata),
        .avl_readdata_o(avl_rdata), .avl_waitrequest_o(avl_wait),
        .b0_req_i(b0_req), .b0_addr_i(b0_addr), .b0_len_i(b0_len),
        .b0_grant_o(b0_grant), .b0_valid_o(b0_valid), .b0_data_o(b0_data),
        .b0_done_o(b0_done), .b0_err_o(b0_err),
        .b1_req_i(b1_req), .b1_addr_i(b1_addr), .b1_len_i(b1_len),
        .b1_grant_o(b1_grant), .b1_valid_o(b1_valid), .b1_data_o(b1_data),
        .b1_done_o(b1_done), .b1_err_o(b1_err),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // RAM macro: image reloads while reset is held (mem[i] = i, word 5 seeded).
    logic [31:0] ram [0:2047];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) ram[i] <= (i == 5) ? 32'h11223344 : 32'(i);
        end else if (ram_we) begin
            for (int k = 0; k < 4; k++)
                if (ram_be[k]) ram[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
        ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] smem [0:2047];
    bit          rr_m;
    int          exp_order[$];
    logic [31:0] eb0[$], eb1[$];
    logic [31:0] exp_rd;

    // transaction parameters for the next round
    bit          a_wr;
    int          a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wd;
    int          b0a, b0l, b1a, b1l;

    task automatic reset_model();
        rr_m = 1'b0;
        for (int i = 0; i < 2048; i++) smem[i] = (i == 5) ? 32'h11223344 : 32'(i);
    endtask

    function automatic bit burst_ok(input int a, input int l);
        return (l >= 1) && (l <= MAXB) && (a + l <= DEPTH);
    endfunction

    function automatic int enc(input int q[$]);
        int v = 0;
        foreach (q[i]) v = v * 4 + q[i] + 1;
        return v;
    endfunction

    // Order of service for requests all present together, and the data each
    // transaction should see given the effects of the ones served before it.
    task automatic model_round(input bit ra, input bit r0, input bit r1);
        bit pa = ra, q0 = r0, q1 = r1;
        int who;
        exp_order.delete(); eb0.delete(); eb1.delete();
        while (pa || q0 || q1) begin
            if (q0)            who = 0;
            else if (pa && q1) who = rr_m ? 1 : 2;
            else if (pa)       who = 2;
            else               who = 1;
            if (who != 0) rr_m = ~rr_m;
            exp_order.push_back(who);
            if (who == 0) begin
                q0 = 1'b0;
                if (burst_ok(b0a, b0l)) for (int i = 0; i < b0l; i++) eb0.push_back(smem[b0a + i]);
            end else if (who == 1) begin
                q1 = 1'b0;
                if (burst_ok(b1a, b1l)) for (int i = 0; i < b1l; i++) eb1.push_back(smem[b1a + i]);
            end else begin
                pa = 1'b0;
                if (a_wr) begin
                    if (a_addr < DEPTH)
                        for (int k = 0; k < 4; k++)
                            if (a_be[k]) smem[a_addr][8*k +: 8] = a_wd[8*k +: 8];
                end else begin
                    exp_rd = (a_addr < DEPTH) ? smem[a_addr] : 32'h0;
                end
            end
        end
    endtask

    // ---------------- round runner ----------------
    int          obs_order[$];
    int          a_lat;
    logic [31:0] rd_obs;
    logic        last_err0, last_err1;

    task automatic run_round(input bit ra, input bit r0, input bit r1);
        bit pend_a = ra, pend0 = r0, pend1 = r1, act0 = 0, act1 = 0;
        int g0 = 0, g1 = 0, k0 = 0, k1 = 0, t0, spur = 0;
        model_round(ra, r0, r1);
        obs_order.delete();
        @(posedge clk); #1;
        avl_read = ra && !a_wr; avl_write = ra && a_wr;
        avl_address = AW'(a_addr); avl_be = a_be; avl_wdata = a_wd;
        b0_req = r0; b0_addr = AW'(b0a); b0_len = 5'(b0l);
        b1_req = r1; b1_addr = AW'(b1a); b1_len = 5'(b1l);
        t0 = cyc;
        for (int b = 0; b < 300 && (pend_a || pend0 || pend1 || act0 || act1); b++) begin
            @(negedge clk);
            if (b0_grant) begin
                if (!pend0) spur++;
                pend0 = 0; act0 = 1; g0 = cyc; k0 = 0; obs_order.push_back(0);
            end
            if (b1_grant) begin
                if (!pend1) spur++;
                pend1 = 0; act1 = 1; g1 = cyc; k1 = 0; obs_order.push_back(1);
            end
            if (b0_valid) begin
                if (!act0 || k0 >= eb0.size()) spur++;
                else begin
                    chk($sformatf("b0 beat%0d data", k0), b0_data, eb0[k0]);
                    chk($sformatf("b0 beat%0d cycle", k0), cyc - g0, 2 + k0);
                    k0++;
                end
            end
            if (b1_valid) begin
                if (!act1 || k1 >= eb1.size()) spur++;
                else begin
                    chk($sformatf("b1 beat%0d data", k1), b1_data, eb1[k1]);
                    chk($sformatf("b1 beat%0d cycle", k1), cyc - g1, 2 + k1);
                    k1++;
                end
            end
            if (b0_done) begin
                if (!act0) spur++;
                else begin
                    last_err0 = b0_err;
                    chk("b0 err", 32'(b0_err), 32'(!burst_ok(b0a, b0l)));
                    chk("b0 beat count", k0, eb0.size());
                    chk("b0 done cycle", cyc - g0, burst_ok(b0a, b0l) ? b0l + 1 : 1);
                    act0 = 0;
                end
            end
            if (b1_done) begin
                if (!act1) spur++;
                else begin
                    last_err1 = b1_err;
                    chk("b1 err", 32'(b1_err), 32'(!burst_ok(b1a, b1l)));
                    chk("b1 beat count", k1, eb1.size());
                    chk("b1 done cycle", cyc - g1, burst_ok(b1a, b1l) ? b1l + 1 : 1);
                    act1 = 0;
                end
            end
            if ((b0_err && !b0_done) || (b1_err && !b1_done)) spur++;
            if (ram_we && (act0 || act1)) spur++;
            if (!avl_wait) begin
                if (!pend_a) spur++;
                else begin
                    pend_a = 0; a_lat = cyc - t0; obs_order.push_back(2);
                    if (!a_wr) rd_obs = avl_rdata;
                end
            end
            @(posedge clk); #1;
            if (!pend0) b0_req = 1'b0;
            if (!pend1) b1_req = 1'b0;
            if (!pend_a) begin avl_read = 1'b0; avl_write = 1'b0; end
        end
        chk("round completes", 32'(pend_a | pend0 | pend1 | act0 | act1), 32'h0);
        chk("service order", enc(obs_order), enc(exp_order));
        chk("spurious events", spur, 0);
        if (ra && !a_wr) chk("avl readdata", rd_obs, exp_rd);
    endtask

    typedef struct {
        int          kind;     // 0 b0 burst, 1 b1 burst, 2 Avalon write, 3 Avalon read
        int          addr;
        int          len;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl[13];
    int   q_exp[$];
    int   g, spur_r;
    logic [2:0] m;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,   10,  4, 4'h0, 32'h0,        1'b0, 32'h0,        0};
        tbl[1]  = '{2,    5,  0, 4'h3, 32'hAABBCCDD, 1'b0, 32'h0,        1};
        tbl[2]  = '{3,    5,  0, 4'h0, 32'h0,        1'b0, 32'h1122CCDD, 2};
        tbl[3]  = '{1, 1490, 12, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        tbl[4]  = '{1,    0,  0, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        tbl[5]  = '{2, 1600,  0, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1};
        tbl[6]  = '{3, 1600,  0, 4'h0, 32'h0,        1'b0, 32'h0,        2};
        tbl[7]  = '{1, 1484, 16, 4'h0, 32'h0,        1'b0, 32'h0,        0};
        tbl[8]  = '{0,  100, 17, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        tbl[9]  = '{0, 1499,  1, 4'h0, 32'h0,        1'b0, 32'h0,        0};
        tbl[10] = '{0, 1499,  2, 4'h0, 32'h0,        1'b1, 32'h0,        0};
        tbl[11] = '{3, 1499,  0, 4'h0, 32'h0,        1'b0, 32'h5DB,      2};
        tbl[12] = '{1,    0, 16, 4'h0, 32'h0,        1'b0, 32'h0,        0};

        reset = 1'b1;
        avl_read = 0; avl_write = 0; avl_address = '0; avl_be = '0; avl_wdata = '0;
        b0_req = 0; b0_addr = '0; b0_len = '0; b1_req = 0; b1_addr = '0; b1_len = '0;
        a_wr = 0; a_addr = 0; a_be = 0; a_wd = 0; b0a = 0; b0l = 1; b1a = 0; b1l = 1;
        reset_model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset waitrequest", 32'(avl_wait), 32'h1);
        chk("reset readdata", avl_rdata, 32'h0);
        chk("reset b0 valid/done/err/grant", {b0_valid, b0_done, b0_err, b0_grant}, 32'h0);
        chk("reset b1 valid/done/err/grant", {b1_valid, b1_done, b1_err, b1_grant}, 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'h0);
        chk("reset ram_addr", 32'(ram_addr), 32'h0);

        // ---- directed table ----
        for (int v = 0; v < 13; v++) begin
            if (tbl[v].kind == 0) begin
                b0a = tbl[v].addr; b0l = tbl[v].len;
                run_round(0, 1, 0);
                chk($sformatf("tbl%0d b0 err", v), 32'(last_err0), 32'(tbl[v].exp_err));
            end else if (tbl[v].kind == 1) begin
                b1a = tbl[v].addr; b1l = tbl[v].len;
                run_round(0, 0, 1);
                chk($sformatf("tbl%0d b1 err", v), 32'(last_err1), 32'(tbl[v].exp_err));
            end else begin
                a_wr = (tbl[v].kind == 2); a_addr = tbl[v].addr; a_be = tbl[v].be; a_wd = tbl[v].wd;
                run_round(1, 0, 0);
                chk($sformatf("tbl%0d avl latency", v), a_lat, tbl[v].exp_lat);
                if (!a_wr) chk($sformatf("tbl%0d readdata", v), rd_obs, tbl[v].exp_rd);
                else if (a_addr >= DEPTH) chk($sformatf("tbl%0d oob write", v), ram[a_addr], 32'(a_addr));
            end
        end

        // ---- reset in the middle of a len-8 b0 burst ----
        @(posedge clk); #1;
        b0_req = 1; b0_addr = AW'(20); b0_len = 5'd8;
        @(negedge clk);
        chk("mid grant", 32'(b0_grant), 32'h1);
        g = cyc;
        @(posedge clk); #1 b0_req = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid 3rd beat valid", 32'(b0_valid), 32'h1);
        chk("mid 3rd beat data", b0_data, 32'd22);
        chk("mid 3rd beat cycle", cyc - g, 4);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post-reset b0 valid/done/err/grant", {b0_valid, b0_done, b0_err, b0_grant}, 32'h0);
        chk("post-reset waitrequest", 32'(avl_wait), 32'h1);
        chk("post-reset ram_we/addr", {ram_we, ram_addr}, 32'h0);
        spur_r = 0;
        repeat (10) begin
            @(negedge clk);
            if (b0_valid || b0_done || b1_valid || b1_done) spur_r++;
        end
        chk("no beats after reset", spur_r, 0);
        reset_model();
        b0a = 40; b0l = 3;
        run_round(0, 1, 0);

        // ---- contention: all three, a lone Avalon access, then Avalon + b1 ----
        a_wr = 1; a_addr = 100; a_be = 4'hF; a_wd = 32'h0BADF00D;
        b0a = 200; b0l = 3; b1a = 300; b1l = 2;
        run_round(1, 1, 1);
        q_exp = '{0, 2, 1};
        chk("triple order b0,avl,b1", enc(obs_order), enc(q_exp));
        a_wr = 0; a_addr = 100;
        run_round(1, 0, 0);
        chk("lone read sees write", rd_obs, 32'h0BADF00D);
        a_wr = 0; a_addr = 7; b1a = 8; b1l = 4;
        run_round(1, 0, 1);
        q_exp = '{1, 2};
        chk("second round b1 first", enc(obs_order), enc(q_exp));

        // ---- randomized rounds against the model ----
        for (int r = 0; r < 40; r++) begin
            m = 3'($urandom_range(1, 7));
            a_wr = 1'($urandom_range(0, 1));
            a_addr = $urandom_range(0, 1520);
            a_be = 4'($urandom_range(0, 15));
            a_wd = $urandom;
            b0a = $urandom_range(0, 1510); b0l = $urandom_range(0, 17);
            b1a = $urandom_range(0, 1510); b1l = $urandom_range(0, 17);
            if (r % 4 == 0) begin b0a = DEPTH - b0l; b1a = DEPTH - b1l + 1; end
            run_round(m[0], m[1], m[2]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
